// File: rtl/ex_stage.sv
// Execute stage of the 5-stage pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register that feeds the memory stage.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_plus_4_ex,
  input  logic [31:0] read_data_1_ex,
  input  logic [31:0] read_data_2_ex,
  input  logic [31:0] immediate_ex,
  input  logic [4:0]  rt_ex,
  input  logic [4:0]  rd_ex,
  input  logic        ctrl_RegDst_ex,
  input  logic        ctrl_ALUSrc_ex,
  input  logic        ctrl_MemToReg_ex,
  input  logic        ctrl_RegWrite_ex,
  input  logic        ctrl_MemRead_ex,
  input  logic        ctrl_MemWrite_ex,
  input  logic        ctrl_Branch_ex,
  input  logic [5:0]  funct_ex,
  input  logic [1:0]  ctrl_ALUOp_ex,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] alu_result_fwd_mem,
  input  logic [31:0] wb_data_fwd,
  output logic [31:0] alu_result_mem,
  output logic [31:0] write_data_mem,
  output logic [31:0] branch_target_mem,
  output logic [4:0]  write_reg_mem,
  output logic        zero_mem,
  output logic        branch_taken_mem,
  output logic        ctrl_RegWrite_mem,
  output logic        ctrl_MemToReg_mem,
  output logic        ctrl_MemRead_mem,
  output logic        ctrl_MemWrite_mem
);

  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic [31:0] w_branch_target;
  logic [4:0]  w_write_reg;

  logic [31:0] r_alu_result;
  logic [31:0] r_write_data;
  logic [31:0] r_branch_target;
  logic [4:0]  r_write_reg;
  logic        r_zero;
  logic        r_branch_taken;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_mem_read;
  logic        r_mem_write;

  // Select 11 is unused by the forwarding unit and falls back to the register file.
  always_comb begin
    case (fwd_a)
      2'b01:   w_op_a = wb_data_fwd;
      2'b10:   w_op_a = alu_result_fwd_mem;
      default: w_op_a = read_data_1_ex;
    endcase
  end

  always_comb begin
    case (fwd_b)
      2'b01:   w_fwd_b = wb_data_fwd;
      2'b10:   w_fwd_b = alu_result_fwd_mem;
      default: w_fwd_b = read_data_2_ex;
    endcase
  end

  assign w_op_b = ctrl_ALUSrc_ex ? immediate_ex : w_fwd_b;

  always_comb begin
    w_alu_result = 32'd0;
    case (ctrl_ALUOp_ex)
      2'b00: w_alu_result = w_op_a + w_op_b;
      2'b01: w_alu_result = w_op_a - w_op_b;
      2'b11: w_alu_result = w_op_a | w_op_b;
      default: begin
        case (funct_ex)
          6'b100000: w_alu_result = w_op_a + w_op_b;
          6'b100010: w_alu_result = w_op_a - w_op_b;
          6'b100100: w_alu_result = w_op_a & w_op_b;
          6'b100101: w_alu_result = w_op_a | w_op_b;
          6'b100111: w_alu_result = ~(w_op_a | w_op_b);
          6'b101010: w_alu_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
          default:   w_alu_result = 32'd0;
        endcase
      end
    endcase
  end

  assign w_zero          = (w_alu_result == 32'd0);
  assign w_branch_target = pc_plus_4_ex + {immediate_ex[29:0], 2'b00};
  assign w_write_reg     = ctrl_RegDst_ex ? rd_ex : rt_ex;

  // rst and flush both produce a bubble; en only gates normal capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_alu_result    <= 32'd0;
      r_write_data    <= 32'd0;
      r_branch_target <= 32'd0;
      r_write_reg     <= 5'd0;
      r_zero          <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
    end else if (en) begin
      r_alu_result    <= w_alu_result;
      r_write_data    <= w_fwd_b;
      r_branch_target <= w_branch_target;
      r_write_reg     <= w_write_reg;
      r_zero          <= w_zero;
      r_branch_taken  <= ctrl_Branch_ex & w_zero;
      r_reg_write     <= ctrl_RegWrite_ex;
      r_mem_to_reg    <= ctrl_MemToReg_ex;
      r_mem_read      <= ctrl_MemRead_ex;
      r_mem_write     <= ctrl_MemWrite_ex;
    end
  end

  assign alu_result_mem    = r_alu_result;
  assign write_data_mem    = r_write_data;
  assign branch_target_mem = r_branch_target;
  assign write_reg_mem     = r_write_reg;
  assign zero_mem          = r_zero;
  assign branch_taken_mem  = r_branch_taken;
  assign ctrl_RegWrite_mem = r_reg_write;
  assign ctrl_MemToReg_mem = r_mem_to_reg;
  assign ctrl_MemRead_mem  = r_mem_read;
  assign ctrl_MemWrite_mem = r_mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand-written hold/flush/reset sequences,
// and randomized traffic checked against a behavioural model of the execute stage.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rt, rd;
    logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [5:0]  funct;
    logic [1:0]  aluop, fa, fb;
    logic [31:0] alu_fwd, wb_fwd;
  } in_t;

  typedef struct packed {
    logic [31:0] alu, wd, bt;
    logic [4:0]  wr;
    logic        zero, taken, regwrite, memtoreg, memread, memwrite;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk, rst, en, flush;
  logic [31:0] pc_plus_4_ex, read_data_1_ex, read_data_2_ex, immediate_ex;
  logic [4:0]  rt_ex, rd_ex;
  logic        ctrl_RegDst_ex, ctrl_ALUSrc_ex, ctrl_MemToReg_ex, ctrl_RegWrite_ex;
  logic        ctrl_MemRead_ex, ctrl_MemWrite_ex, ctrl_Branch_ex;
  logic [5:0]  funct_ex;
  logic [1:0]  ctrl_ALUOp_ex, fwd_a, fwd_b;
  logic [31:0] alu_result_fwd_mem, wb_data_fwd;
  logic [31:0] alu_result_mem, write_data_mem, branch_target_mem;
  logic [4:0]  write_reg_mem;
  logic        zero_mem, branch_taken_mem;
  logic        ctrl_RegWrite_mem, ctrl_MemToReg_mem, ctrl_MemRead_mem, ctrl_MemWrite_mem;

  int n_total = 0;
  int n_pass  = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .pc_plus_4_ex(pc_plus_4_ex), .read_data_1_ex(read_data_1_ex),
    .read_data_2_ex(read_data_2_ex), .immediate_ex(immediate_ex),
    .rt_ex(rt_ex), .rd_ex(rd_ex),
    .ctrl_RegDst_ex(ctrl_RegDst_ex), .ctrl_ALUSrc_ex(ctrl_ALUSrc_ex),
    .ctrl_MemToReg_ex(ctrl_MemToReg_ex), .ctrl_RegWrite_ex(ctrl_RegWrite_ex),
    .ctrl_MemRead_ex(ctrl_MemRead_ex), .ctrl_MemWrite_ex(ctrl_MemWrite_ex),
    .ctrl_Branch_ex(ctrl_Branch_ex), .funct_ex(funct_ex), .ctrl_ALUOp_ex(ctrl_ALUOp_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .alu_result_fwd_mem(alu_result_fwd_mem), .wb_data_fwd(wb_data_fwd),
    .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
    .branch_target_mem(branch_target_mem), .write_reg_mem(write_reg_mem),
    .zero_mem(zero_mem), .branch_taken_mem(branch_taken_mem),
    .ctrl_RegWrite_mem(ctrl_RegWrite_mem), .ctrl_MemToReg_mem(ctrl_MemToReg_mem),
    .ctrl_MemRead_mem(ctrl_MemRead_mem), .ctrl_MemWrite_mem(ctrl_MemWrite_mem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  function automatic out_t model(in_t v);
    out_t o;
    longint a, b, r;
    int     sa, sb;
    o  = '0;
    a  = (v.fa == 2'd1) ? v.wb_fwd : (v.fa == 2'd2) ? v.alu_fwd : v.rd1;
    o.wd = (v.fb == 2'd1) ? v.wb_fwd : (v.fb == 2'd2) ? v.alu_fwd : v.rd2;
    b  = v.alusrc ? v.imm : o.wd;
    sa = int'(a[31:0]);
    sb = int'(b[31:0]);
    r  = 0;
    if (v.aluop == 2'd0)      r = a + b;
    else if (v.aluop == 2'd1) r = a - b;
    else if (v.aluop == 2'd3) r = a | b;
    else if (v.funct == 6'd32) r = a + b;
    else if (v.funct == 6'd34) r = a - b;
    else if (v.funct == 6'd36) r = a & b;
    else if (v.funct == 6'd37) r = a | b;
    else if (v.funct == 6'd39) r = ~(a | b);
    else if (v.funct == 6'd42) r = (sa < sb) ? 1 : 0;
    o.alu      = r[31:0];
    o.zero     = (o.alu == 0);
    o.taken    = v.branch && o.zero;
    o.bt       = v.pc4 + v.imm * 4;
    o.wr       = v.regdst ? v.rd : v.rt;
    o.regwrite = v.regwrite;
    o.memtoreg = v.memtoreg;
    o.memread  = v.memread;
    o.memwrite = v.memwrite;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(in_t v);
    pc_plus_4_ex = v.pc4;  read_data_1_ex = v.rd1;  read_data_2_ex = v.rd2;
    immediate_ex = v.imm;  rt_ex = v.rt;  rd_ex = v.rd;
    ctrl_RegDst_ex = v.regdst;  ctrl_ALUSrc_ex = v.alusrc;
    ctrl_MemToReg_ex = v.memtoreg;  ctrl_RegWrite_ex = v.regwrite;
    ctrl_MemRead_ex = v.memread;  ctrl_MemWrite_ex = v.memwrite;
    ctrl_Branch_ex = v.branch;  funct_ex = v.funct;  ctrl_ALUOp_ex = v.aluop;
    fwd_a = v.fa;  fwd_b = v.fb;
    alu_result_fwd_mem = v.alu_fwd;  wb_data_fwd = v.wb_fwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t rand_in();
    in_t v;
    logic [5:0] functs [7];
    functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
    v = '0;
    v.pc4 = $urandom;  v.imm = $urandom;
    v.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    v.rd2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    v.alu_fwd = $urandom;  v.wb_fwd = $urandom;
    v.rt = 5'($urandom);  v.rd = 5'($urandom);
    {v.regdst, v.alusrc, v.memtoreg, v.regwrite, v.memread, v.memwrite, v.branch} = 7'($urandom);
    v.aluop = 2'($urandom);  v.fa = 2'($urandom);  v.fb = 2'($urandom);
    v.funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 6)];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  out_t exp_q[$];

  function automatic out_t read_dut();
    out_t o;
    o = {alu_result_mem, write_data_mem, branch_target_mem, write_reg_mem, zero_mem,
         branch_taken_mem, ctrl_RegWrite_mem, ctrl_MemToReg_mem, ctrl_MemRead_mem,
         ctrl_MemWrite_mem};
    return o;
  endfunction

  task automatic check(string name, out_t exp);
    out_t act;
    act = read_dut();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got alu=%h wd=%h bt=%h wr=%0d z=%b tk=%b ctl=%b%b%b%b | expected alu=%h wd=%h bt=%h wr=%0d z=%b tk=%b ctl=%b%b%b%b",
                  name, act.alu, act.wd, act.bt, act.wr, act.zero, act.taken,
                  act.regwrite, act.memtoreg, act.memread, act.memwrite,
                  exp.alu, exp.wd, exp.bt, exp.wr, exp.zero, exp.taken,
                  exp.regwrite, exp.memtoreg, exp.memread, exp.memwrite);
  endtask

  task automatic check_next(string name);
    out_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got empty queue, expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  // ---------------- test ----------------
  vec_t vt [10];
  out_t held, cur;
  in_t  v;

  initial begin
    for (int k = 0; k < 10; k++) vt[k] = '0;
    // R-type add
    vt[0].i.rd1 = 5; vt[0].i.rd2 = 7; vt[0].i.regdst = 1; vt[0].i.rd = 3;
    vt[0].i.regwrite = 1; vt[0].i.aluop = 2; vt[0].i.funct = 6'b100000;
    vt[0].e.alu = 12; vt[0].e.wd = 7; vt[0].e.wr = 3; vt[0].e.regwrite = 1;
    // beq taken, backward target
    vt[1].i.rd1 = 32'h1234; vt[1].i.rd2 = 32'h1234; vt[1].i.branch = 1; vt[1].i.aluop = 1;
    vt[1].i.pc4 = 32'h100; vt[1].i.imm = 32'hFFFF_FFFE;
    vt[1].e.wd = 32'h1234; vt[1].e.bt = 32'hF8; vt[1].e.zero = 1; vt[1].e.taken = 1;
    // SLT through both forwarding paths
    vt[2].i.fa = 2; vt[2].i.alu_fwd = 9; vt[2].i.fb = 1; vt[2].i.wb_fwd = 4;
    vt[2].i.aluop = 2; vt[2].i.funct = 6'b101010;
    vt[2].e.alu = 0; vt[2].e.wd = 4; vt[2].e.zero = 1;
    vt[3] = vt[2]; vt[3].i.alu_fwd = 4; vt[3].i.wb_fwd = 9;
    vt[3].e.alu = 1; vt[3].e.wd = 9; vt[3].e.zero = 0;
    vt[4] = vt[2]; vt[4].i.alu_fwd = 32'hFFFF_FFFF; vt[4].i.wb_fwd = 1;
    vt[4].e.alu = 1; vt[4].e.wd = 1; vt[4].e.zero = 0;
    // sw: immediate address, forwarded store data
    vt[5].i.rd1 = 32'h40; vt[5].i.alusrc = 1; vt[5].i.imm = 8; vt[5].i.fb = 1;
    vt[5].i.wb_fwd = 32'hDEAD; vt[5].i.memwrite = 1;
    vt[5].e.alu = 32'h48; vt[5].e.wd = 32'hDEAD; vt[5].e.bt = 32'h20; vt[5].e.memwrite = 1;
    // undefined funct yields 0
    vt[6].i.rd1 = 5; vt[6].i.rd2 = 3; vt[6].i.aluop = 2; vt[6].i.funct = 6'b111111;
    vt[6].e.wd = 3; vt[6].e.zero = 1;
    // AND with select 11 ignoring forward sources
    vt[7].i.rd1 = 32'hF0F0; vt[7].i.rd2 = 32'hFF00; vt[7].i.fa = 3; vt[7].i.fb = 3;
    vt[7].i.alu_fwd = 1; vt[7].i.wb_fwd = 2; vt[7].i.aluop = 2; vt[7].i.funct = 6'b100100;
    vt[7].i.rt = 9;
    vt[7].e.alu = 32'hF000; vt[7].e.wd = 32'hFF00; vt[7].e.wr = 9;
    // NOR of zeros
    vt[8].i.aluop = 2; vt[8].i.funct = 6'b100111; vt[8].e.alu = 32'hFFFF_FFFF;
    // ALUOp 11 OR with immediate, load-style controls
    vt[9].i.rd1 = 32'h0F; vt[9].i.rd2 = 32'hF0; vt[9].i.alusrc = 1; vt[9].i.imm = 32'h100;
    vt[9].i.aluop = 3; vt[9].i.memread = 1; vt[9].i.memtoreg = 1;
    vt[9].e.alu = 32'h10F; vt[9].e.wd = 32'hF0; vt[9].e.bt = 32'h400;
    vt[9].e.memread = 1; vt[9].e.memtoreg = 1;

    // Reset state
    rst = 1; flush = 0; en = 1;
    drive(vt[0].i);
    step(); step();
    check("reset_state", '0);
    rst = 0;

    // Directed table
    for (int k = 0; k < 10; k++) begin
      drive(vt[k].i);
      step();
      check($sformatf("vec%0d", k), vt[k].e);
    end

    // Hold with en=0 while inputs change
    drive(vt[0].i); step(); check("hold_load", vt[0].e);
    en = 0;
    for (int k = 0; k < 3; k++) begin
      drive(rand_in()); step(); check($sformatf("hold_%0d", k), vt[0].e);
    end
    flush = 1; drive(vt[1].i); step(); check("flush_en0", '0);
    flush = 0; en = 1; drive(vt[5].i); step(); check("after_flush", vt[5].e);
    flush = 1; drive(vt[0].i); step(); check("flush_en1", '0);
    flush = 0; drive(vt[3].i); step(); check("after_flush2", vt[3].e);
    rst = 1; flush = 1; drive(vt[1].i); step(); check("rst_over_flush", '0);
    rst = 0; flush = 0; step(); check("after_rst", vt[1].e);

    // Randomized traffic against the model
    held = vt[1].e;
    for (int n = 0; n < 400; n++) begin
      v     = rand_in();
      rst   = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      drive(v);
      if (rst || flush) cur = '0;
      else if (en)      cur = model(v);
      else              cur = held;
      held = cur;
      exp_q.push_back(cur);
      step();
      check_next($sformatf("rand_%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
